mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports listed clock and reset first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  EX-stage result present.
REQ-005 in_ALU_result  input  16  ALU output; memory address for loads/stores.
REQ-006 in_SW_data  input  16  store data.
REQ-007 in_MemRead, in_MemWrite, in_MemToReg, in_RegWrite, in_HLT  input  1 each  EX-stage control bits.
REQ-008 in_DstReg  input  4  destination register index.
REQ-009 stall  output  1  upstream holds all in_* stable while high.
REQ-010 mem_req, mem_wr  output  1 each  data-memory request, write qualifier.
REQ-011 mem_addr, mem_wdata  output  16 each  request address, write data.
REQ-012 mem_ack  input  1  memory completion, sampled only in ACCESS.
REQ-013 mem_rdata  input  16  read data, valid when mem_ack=1.
REQ-014 out_valid, out_RegWrite, out_HLT  output  1 each  MEM/WB result strobe and controls.
REQ-015 out_WB_data  output  16  writeback value.
REQ-016 out_DstReg  output  4  writeback register index.
REQ-017 mem_err  output  1  sticky memory-timeout flag.

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS, HALTED.
REQ-019 stall SHALL be combinational: 1 in ACCESS or HALTED, else 0.
REQ-020 IDLE, in_valid=0: next state IDLE, out_valid=0 next cycle.
REQ-021 IDLE, in_valid=1, no MemRead/MemWrite: register result; next cycle out_valid=1, out_WB_data=in_ALU_result, RegWrite/DstReg/HLT passed through (1-cycle latency).
REQ-022 IDLE, in_valid=1, MemRead or MemWrite: latch op; enter ACCESS; mem_req=1, mem_addr=in_ALU_result, mem_wdata=in_SW_data, mem_wr=in_MemWrite, all registered and held constant through ACCESS.
REQ-023 MemRead and MemWrite both set: SHALL perform a write; out_WB_data=latched ALU result.
REQ-024 ACCESS with mem_ack=1 at a rising edge: next cycle mem_req=0, state IDLE, out_valid=1 for exactly one cycle, out_WB_data = MemToReg ? mem_rdata sampled at that edge : latched ALU result.
REQ-025 Minimum memory-op latency SHALL be 2 cycles (capture edge to out_valid), when mem_ack is high in the first ACCESS cycle.
REQ-026 mem_ack outside ACCESS SHALL be ignored.
REQ-027 A 4-bit counter SHALL count ACCESS cycles; at 15 cycles without ack: request abandoned, mem_err set (sticky until reset), out_valid pulses with out_RegWrite=0 and out_WB_data=0x0000, return to IDLE.
REQ-028 Valid instruction with in_HLT=1: result emitted per REQ-021/024 with out_HLT=1; then state HALTED, all inputs ignored, out_valid=0, until reset.
REQ-029 out_valid SHALL be low every cycle no result is produced; out_* other than out_valid hold last values.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, counter 0, and all outputs 0 (mem_req, mem_wr, mem_addr, mem_wdata, out_*, mem_err); mid-ACCESS request dropped, no result emitted.
REQ-031 First capture SHALL occur on the first rising edge with rst_n high.

Verification
REQ-032 ALU op in_ALU_result=0x1234, RegWrite=1, DstReg=3 -> next cycle out_valid=1, out_WB_data=0x1234, out_DstReg=3, stall=0 throughout.
REQ-033 Load addr 0x0040, MemToReg=1, ack 3 cycles later with rdata=0xBEEF -> stall=1 and mem_req=1 for 3 cycles, then out_WB_data=0xBEEF, out_valid one cycle.
REQ-034 Store addr 0x0010 data 0xA5A5, ack first cycle -> mem_wr=1, mem_wdata=0xA5A5, out_valid 2 cycles after capture, out_WB_data=0x0010.
REQ-035 Load never acked -> after 15 ACCESS cycles mem_err=1, out_RegWrite=0, out_WB_data=0x0000, stall drops; mem_err remains 1.
REQ-036 HLT op followed by valid ALU ops -> one out_valid with out_HLT=1, then stall=1, no further out_valid.
REQ-037 rst_n asserted mid-ACCESS -> mem_req and stall low immediately, no out_valid; next op after release processed normally.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage with a handshaked data-memory port,
// access timeout, and halt handling.
module mem_access_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_ALU_result,
  input  logic [15:0] in_SW_data,
  input  logic        in_MemRead,
  input  logic        in_MemWrite,
  input  logic        in_MemToReg,
  input  logic        in_RegWrite,
  input  logic        in_HLT,
  input  logic [3:0]  in_DstReg,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        out_valid,
  output logic        out_RegWrite,
  output logic        out_HLT,
  output logic [15:0] out_WB_data,
  output logic [3:0]  out_DstReg,
  output logic        mem_err
);
  typedef enum logic [1:0] {IDLE, ACCESS, HALTED} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d, dst_q, dst_d, odst_q, odst_d;
  logic        req_q, req_d, wr_q, wr_d, m2r_q, m2r_d, rw_q, rw_d, hlt_q, hlt_d;
  logic        ov_q, ov_d, orw_q, orw_d, ohlt_q, ohlt_d, err_q, err_d;
  logic [15:0] addr_q, addr_d, wdata_q, wdata_d, owb_q, owb_d;
  logic        done;
  assign stall        = state_q != IDLE;
  assign mem_req      = req_q;
  assign mem_wr       = wr_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign out_valid    = ov_q;
  assign out_RegWrite = orw_q;
  assign out_HLT      = ohlt_q;
  assign out_WB_data  = owb_q;
  assign out_DstReg   = odst_q;
  assign mem_err      = err_q;
  // An access ends on ack, or after its 15th unacknowledged cycle
  assign done = mem_ack || cnt_q == 4'd14;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    m2r_d   = m2r_q;
    rw_d    = rw_q;
    dst_d   = dst_q;
    hlt_d   = hlt_q;
    ov_d    = 1'b0;
    orw_d   = orw_q;
    ohlt_d  = ohlt_q;
    owb_d   = owb_q;
    odst_d  = odst_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (in_valid) begin
        if (in_MemRead || in_MemWrite) begin
          state_d = ACCESS;
          cnt_d   = 4'd0;
          req_d   = 1'b1;
          wr_d    = in_MemWrite;
          addr_d  = in_ALU_result;
          wdata_d = in_SW_data;
          m2r_d   = in_MemToReg && !in_MemWrite;
          rw_d    = in_RegWrite;
          dst_d   = in_DstReg;
          hlt_d   = in_HLT;
        end else begin
          state_d = in_HLT ? HALTED : IDLE;
          ov_d    = 1'b1;
          owb_d   = in_ALU_result;
          orw_d   = in_RegWrite;
          odst_d  = in_DstReg;
          ohlt_d  = in_HLT;
        end
      end
      ACCESS: if (done) begin
        state_d = hlt_q ? HALTED : IDLE;
        req_d   = 1'b0;
        wr_d    = 1'b0;
        ov_d    = 1'b1;
        owb_d   = !mem_ack ? 16'h0000 : m2r_q ? mem_rdata : addr_q;
        orw_d   = mem_ack && rw_q;
        odst_d  = dst_q;
        ohlt_d  = hlt_q;
        err_d   = err_q || !mem_ack;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      m2r_q   <= 1'b0;
      rw_q    <= 1'b0;
      dst_q   <= '0;
      hlt_q   <= 1'b0;
      ov_q    <= 1'b0;
      orw_q   <= 1'b0;
      ohlt_q  <= 1'b0;
      owb_q   <= '0;
      odst_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      m2r_q   <= m2r_d;
      rw_q    <= rw_d;
      dst_q   <= dst_d;
      hlt_q   <= hlt_d;
      ov_q    <= ov_d;
      orw_q   <= orw_d;
      ohlt_q  <= ohlt_d;
      owb_q   <= owb_d;
      odst_q  <= odst_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: vector table for ALU ops, scoreboarded result checks,
// and directed sequences for memory handshake, timeout, reset and halt.
module tb_mem_access_stage;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_MemRead = 1'b0, in_MemWrite = 1'b0;
  logic        in_MemToReg = 1'b0, in_RegWrite = 1'b0, in_HLT = 1'b0;
  logic [15:0] in_ALU_result = '0, in_SW_data = '0, mem_rdata = '0;
  logic [3:0]  in_DstReg = '0;
  logic        mem_ack = 1'b0;
  logic        stall, mem_req, mem_wr, out_valid, out_RegWrite, out_HLT, mem_err;
  logic [15:0] mem_addr, mem_wdata, out_WB_data;
  logic [3:0]  out_DstReg;
  int tests = 0, fails = 0;

  typedef struct {logic [15:0] wb; logic [3:0] dst; logic rw; logic hlt;} res_t;
  typedef struct {logic [15:0] alu; logic rw; logic [3:0] dst; logic [15:0] exp_wb; logic exp_rw;} vec_t;
  res_t q[$];
  vec_t vecs[4];

  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ALU_result(in_ALU_result),
    .in_SW_data(in_SW_data), .in_MemRead(in_MemRead), .in_MemWrite(in_MemWrite),
    .in_MemToReg(in_MemToReg), .in_RegWrite(in_RegWrite), .in_HLT(in_HLT),
    .in_DstReg(in_DstReg), .stall(stall), .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_RegWrite(out_RegWrite), .out_HLT(out_HLT),
    .out_WB_data(out_WB_data), .out_DstReg(out_DstReg), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] wb, input logic [3:0] dst, input logic rw, input logic hlt);
    res_t r;
    r.wb = wb; r.dst = dst; r.rw = rw; r.hlt = hlt;
    q.push_back(r);
  endtask

  always @(posedge clk) begin
    #1;
    if (out_valid === 1'b1) begin
      if (q.size() == 0) check("unexpected_out_valid", 16'd1, 16'd0);
      else begin
        res_t r;
        r = q.pop_front();
        check("out_WB_data", out_WB_data, r.wb);
        check("out_DstReg", {12'd0, out_DstReg}, {12'd0, r.dst});
        check("out_RegWrite", {15'd0, out_RegWrite}, {15'd0, r.rw});
        check("out_HLT", {15'd0, out_HLT}, {15'd0, r.hlt});
      end
    end
  end

  task automatic alu_op(input logic [15:0] alu, input logic rw, input logic [3:0] dst, input logic hlt);
    in_valid = 1'b1; in_MemRead = 1'b0; in_MemWrite = 1'b0; in_MemToReg = 1'b0;
    in_ALU_result = alu; in_RegWrite = rw; in_DstReg = dst; in_HLT = hlt;
  endtask

  // ack_at: ACCESS cycle (1..15) in which mem_ack is raised, 0 = never
  task automatic mem_op(input logic [15:0] a, input logic [15:0] d, input logic rd, input logic wr,
                        input logic m2r, input logic [3:0] dst, input int ack_at,
                        input logic [15:0] rdata, input logic [15:0] exp_wb, input logic exp_rw);
    in_valid = 1'b1; in_MemRead = rd; in_MemWrite = wr; in_MemToReg = m2r; in_HLT = 1'b0;
    in_ALU_result = a; in_SW_data = d; in_RegWrite = 1'b1; in_DstReg = dst;
    step();
    for (int c = 1; c <= 15; c++) begin
      check("stall_access", {15'd0, stall}, 16'd1);
      check("mem_req", {15'd0, mem_req}, 16'd1);
      check("mem_wr", {15'd0, mem_wr}, {15'd0, wr});
      check("mem_addr", mem_addr, a);
      check("mem_wdata", mem_wdata, d);
      check("no_early_valid", {15'd0, out_valid}, 16'd0);
      if (c == ack_at) begin
        mem_ack = 1'b1; mem_rdata = rdata;
        push(exp_wb, dst, exp_rw, 1'b0);
        step();
        break;
      end
      if (c == 15) begin
        push(exp_wb, dst, exp_rw, 1'b0);
        step();
      end else step();
    end
    mem_ack = 1'b0; in_valid = 1'b0;
    check("done_valid", {15'd0, out_valid}, 16'd1);
    check("done_stall", {15'd0, stall}, 16'd0);
    check("done_req", {15'd0, mem_req}, 16'd0);
  endtask

  initial begin
    vecs[0] = '{16'h1234, 1'b1, 4'd3,  16'h1234, 1'b1};
    vecs[1] = '{16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0};
    vecs[2] = '{16'hFFFF, 1'b1, 4'd15, 16'hFFFF, 1'b1};
    vecs[3] = '{16'h8001, 1'b1, 4'd7,  16'h8001, 1'b1};
    #1;
    check("rst_stall", {15'd0, stall}, 16'd0);
    check("rst_req", {15'd0, mem_req}, 16'd0);
    check("rst_valid", {15'd0, out_valid}, 16'd0);
    check("rst_wb", out_WB_data, 16'h0000);
    check("rst_err", {15'd0, mem_err}, 16'd0);
    step(); step();
    rst_n = 1'b1;
    // back-to-back ALU results, one per cycle
    for (int i = 0; i < 4; i++) begin
      alu_op(vecs[i].alu, vecs[i].rw, vecs[i].dst, 1'b0);
      push(vecs[i].exp_wb, vecs[i].dst, vecs[i].exp_rw, 1'b0);
      step();
      check("alu_stall", {15'd0, stall}, 16'd0);
      check("alu_valid", {15'd0, out_valid}, 16'd1);
    end
    in_valid = 1'b0;
    mem_ack = 1'b1;
    step(); step();
    check("hold_wb", out_WB_data, 16'h8001);
    check("hold_dst", {12'd0, out_DstReg}, 16'd7);
    check("idle_ack_ignored", {15'd0, out_valid}, 16'd0);
    mem_ack = 1'b0;
    mem_op(16'h0040, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd5, 3, 16'hBEEF, 16'hBEEF, 1'b1);
    mem_op(16'h0010, 16'hA5A5, 1'b0, 1'b1, 1'b0, 4'd2, 1, 16'h0000, 16'h0010, 1'b1);
    mem_op(16'h0022, 16'h5A5A, 1'b1, 1'b1, 1'b1, 4'd9, 2, 16'hDEAD, 16'h0022, 1'b1);
    mem_op(16'h0030, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd4, 1, 16'h7777, 16'h0030, 1'b1);
    check("err_before_timeout", {15'd0, mem_err}, 16'd0);
    mem_op(16'h0050, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd6, 0, 16'h0000, 16'h0000, 1'b0);
    check("err_set", {15'd0, mem_err}, 16'd1);
    alu_op(16'h4321, 1'b1, 4'd1, 1'b0);
    push(16'h4321, 4'd1, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    check("err_sticky", {15'd0, mem_err}, 16'd1);
    // reset in the middle of an access
    in_valid = 1'b1; in_MemRead = 1'b1; in_MemWrite = 1'b0; in_MemToReg = 1'b1;
    in_ALU_result = 16'h0060; in_DstReg = 4'd8;
    step(); step();
    check("pre_rst_req", {15'd0, mem_req}, 16'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", {15'd0, mem_req}, 16'd0);
    check("mid_rst_stall", {15'd0, stall}, 16'd0);
    check("mid_rst_err", {15'd0, mem_err}, 16'd0);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_valid", {15'd0, out_valid}, 16'd0);
    mem_op(16'h0070, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd10, 2, 16'hCAFE, 16'hCAFE, 1'b1);
    // halt followed by further valid work
    alu_op(16'h0BAD, 1'b1, 4'd12, 1'b1);
    push(16'h0BAD, 4'd12, 1'b1, 1'b1);
    step();
    check("hlt_valid", {15'd0, out_valid}, 16'd1);
    for (int i = 0; i < 5; i++) begin
      alu_op(16'h1000 + 16'(i), 1'b1, 4'd1, 1'b0);
      mem_ack = 1'b1;
      step();
      check("halted_stall", {15'd0, stall}, 16'd1);
      check("halted_req", {15'd0, mem_req}, 16'd0);
    end
    in_valid = 1'b0; mem_ack = 1'b0;
    step();
    check("queue_empty", 16'(q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
